// File: rtl/port_match_checker.sv
`timescale 1ns/1ps
// In-line checker: queues the expected value of each observed input and grades each observed output.
// Latency: every event shows up on the counters, pending, overflow and err one cycle after the sampling edge.
// Backpressure: none. A push while full with no pop in the same cycle is dropped and sets overflow.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_en, portin       : input-side strobe and data of the observed stage (pushes an expected value)
//   out_en, portout     : output-side strobe and data of the observed stage (pops and grades the head)
//   match_cnt           : outputs inside the latency window with the correct value
//   mismatch_cnt        : outputs inside the latency window with a wrong value
//   early_cnt           : outputs that arrived before MIN_LAT
//   timeout_cnt         : expected entries dropped after waiting MAX_LAT cycles
//   spurious_cnt        : outputs seen while nothing was expected
//   pending             : number of queued expected entries
//   overflow            : sticky, a push was attempted while the queue was full
//   err                 : one-cycle pulse for any cycle with a non-match event
module port_match_checker #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int MIN_LAT  = 1,
    parameter int MAX_LAT  = 5,
    parameter int XFORM_EN = 1,
    parameter int THRESH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [DATA_W-1:0]        portin,
    input  logic                     out_en,
    input  logic [DATA_W-1:0]        portout,
    output logic [15:0]              match_cnt,
    output logic [15:0]              mismatch_cnt,
    output logic [15:0]              early_cnt,
    output logic [15:0]              timeout_cnt,
    output logic [15:0]              spurious_cnt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = 8;

    localparam logic [AGE_W-1:0] MIN_AGE   = AGE_W'(MIN_LAT);
    localparam logic [AGE_W-1:0] MAX_AGE   = AGE_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    // One queue slot: the expected output value and its age.
    // The stored age is the age the entry will have at the next evaluating
    // edge, so a freshly pushed entry is stored with age 1.
    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t            q_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    entry_t            head;
    logic [DATA_W-1:0] exp_dat;
    logic              q_empty;
    logic              q_full;
    logic              do_pop;
    logic              do_push;
    logic              ev_match;
    logic              ev_mism;
    logic              ev_early;
    logic              ev_tmo;
    logic              ev_spur;
    logic              ev_ovf;
    logic              ev_err;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && v != 16'hFFFF) begin
            return v + 16'd1;
        end
        return v;
    endfunction

    // Expected value, computed at push time. The +1 wraps naturally at DATA_W.
    always_comb begin
        exp_dat = portin;
        if (XFORM_EN != 0 && int'(portin) >= THRESH) begin
            exp_dat = portin + DATA_W'(1);
        end
    end

    // Head grading. Only the pre-push queue is visible here, so an entry
    // pushed this cycle can never be the one popped.
    always_comb begin
        head     = q_mem[rd_ptr];
        q_empty  = (pending == '0);
        q_full   = (pending == FULL_CNT);
        do_pop   = 1'b0;
        do_push  = 1'b0;
        ev_match = 1'b0;
        ev_mism  = 1'b0;
        ev_early = 1'b0;
        ev_tmo   = 1'b0;
        ev_spur  = 1'b0;
        ev_ovf   = 1'b0;

        if (out_en) begin
            if (q_empty) begin
                ev_spur = 1'b1;
            end else begin
                do_pop = 1'b1;
                if (head.age < MIN_AGE) begin
                    ev_early = 1'b1;
                end else if (portout == head.dat) begin
                    ev_match = 1'b1;
                end else begin
                    ev_mism = 1'b1;
                end
            end
        end else if (!q_empty && head.age >= MAX_AGE) begin
            do_pop = 1'b1;
            ev_tmo = 1'b1;
        end

        // A same-cycle pop frees a slot, so a push into a full queue is still taken.
        if (in_en) begin
            if (q_full && !do_pop) begin
                ev_ovf = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end

        ev_err = ev_mism | ev_early | ev_tmo | ev_spur | ev_ovf;
    end

    // Queue storage: no reset needed, validity is tracked by the pointers.
    // Ages saturate at MAX_LAT; the head is always retired at that age, and
    // younger entries are strictly younger because pushes are one per cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_mem[i].age < MAX_AGE) begin
                q_mem[i].age <= q_mem[i].age + AGE_W'(1);
            end
        end
        // Written after the aging loop so the new entry's age wins.
        if (!rst && do_push) begin
            q_mem[wr_ptr] <= '{dat: exp_dat, age: AGE_W'(1)};
        end
    end

    // Pointers, occupancy, counters and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            pending      <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            early_cnt    <= '0;
            timeout_cnt  <= '0;
            spurious_cnt <= '0;
            overflow     <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase

            match_cnt    <= sat_inc(match_cnt,    ev_match);
            mismatch_cnt <= sat_inc(mismatch_cnt, ev_mism);
            early_cnt    <= sat_inc(early_cnt,    ev_early);
            timeout_cnt  <= sat_inc(timeout_cnt,  ev_tmo);
            spurious_cnt <= sat_inc(spurious_cnt, ev_spur);
            overflow     <= overflow | ev_ovf;
            err          <= ev_err;
        end
    end

endmodule

// File: tb/tb_port_match_checker.sv
`timescale 1ns/1ps
module tb_port_match_checker;

    localparam int DEPTH   = 8;
    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_en = 1'b0;
    logic [7:0]  portin = 8'd0;
    logic        out_en = 1'b0;
    logic [7:0]  portout = 8'd0;

    logic [15:0] match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt;
    logic [3:0]  pending;
    logic        overflow, err;

    // Second instance with a long window so the queue can actually fill.
    logic [15:0] b_match_cnt, b_mismatch_cnt, b_early_cnt, b_timeout_cnt, b_spurious_cnt;
    logic [3:0]  b_pending;
    logic        b_overflow, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of expected values plus the edge index at which each was pushed.
    logic [7:0] q_exp[$];
    int         q_t[$];
    int         cyc = 0;
    int         m_match = 0, m_mism = 0, m_early = 0, m_tmo = 0, m_spur = 0;
    bit         m_ovf = 0, m_err = 0;

    port_match_checker #(.DATA_W(8), .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT),
                         .XFORM_EN(1), .THRESH(4)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .portin(portin), .out_en(out_en), .portout(portout),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .early_cnt(early_cnt),
        .timeout_cnt(timeout_cnt), .spurious_cnt(spurious_cnt), .pending(pending),
        .overflow(overflow), .err(err)
    );

    port_match_checker #(.DATA_W(8), .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .MAX_LAT(20),
                         .XFORM_EN(1), .THRESH(4)) dut_big (
        .clk(clk), .rst(rst), .in_en(in_en), .portin(portin), .out_en(out_en), .portout(portout),
        .match_cnt(b_match_cnt), .mismatch_cnt(b_mismatch_cnt), .early_cnt(b_early_cnt),
        .timeout_cnt(b_timeout_cnt), .spurious_cnt(b_spurious_cnt), .pending(b_pending),
        .overflow(b_overflow), .err(b_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xf(input logic [7:0] p);
        logic [7:0] r;
        r = (p < 8'd4) ? p : p + 8'd1;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Model of one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        bit popped;
        bit ev;
        int age;
        popped = 0;
        ev     = 0;
        cyc++;
        if (rst) begin
            q_exp.delete();
            q_t.delete();
            m_match = 0; m_mism = 0; m_early = 0; m_tmo = 0; m_spur = 0;
            m_ovf = 0; m_err = 0;
            return;
        end
        if (out_en) begin
            if (q_exp.size() == 0) begin
                m_spur = sat(m_spur);
                ev = 1;
            end else begin
                age = cyc - q_t[0];
                if (age < MIN_LAT) begin
                    m_early = sat(m_early);
                    ev = 1;
                end else if (portout == q_exp[0]) begin
                    m_match = sat(m_match);
                end else begin
                    m_mism = sat(m_mism);
                    ev = 1;
                end
                void'(q_exp.pop_front());
                void'(q_t.pop_front());
                popped = 1;
            end
        end else if (q_exp.size() != 0 && (cyc - q_t[0]) >= MAX_LAT) begin
            m_tmo = sat(m_tmo);
            void'(q_exp.pop_front());
            void'(q_t.pop_front());
            popped = 1;
            ev = 1;
        end
        if (in_en) begin
            if (q_exp.size() >= DEPTH && !popped) begin
                m_ovf = 1;
                ev = 1;
            end else begin
                q_exp.push_back(xf(portin));
                q_t.push_back(cyc);
            end
        end
        m_err = ev;
    endtask

    // Drive one cycle of inputs, clock it, update the model, then settle before sampling.
    task automatic step(input logic r, input logic ie, input logic [7:0] pi,
                        input logic oe, input logic [7:0] po);
        rst = r; in_en = ie; portin = pi; out_en = oe; portout = po;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        end
        n_checks++;
        if ({match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h expected all zero",
                     {match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt});
        end
        n_checks++;
        if ({pending, overflow, err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_flags: pending=%0d overflow=%b err=%b expected 0/0/0",
                     pending, overflow, err);
        end
    endtask

    task automatic test_match();
        step(1'b0, 1'b1, 8'd3, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd3);
        n_checks++;
        if (match_cnt !== 16'(m_match) || m_match != 1) begin
            n_fail++;
            $display("FAIL basic_match: match_cnt=%0d expected %0d", match_cnt, m_match);
        end
        n_checks++;
        if (pending !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_match_flags: pending=%0d err=%b expected 0/0", pending, err);
        end
    endtask

    task automatic test_xform();
        // 5 is above the threshold, so 6 is expected.
        step(1'b0, 1'b1, 8'd5, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd6);
        n_checks++;
        if (match_cnt !== 16'(m_match) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL xform_match: match_cnt=%0d err=%b expected %0d/0", match_cnt, err, m_match);
        end
        // 7 passed through unchanged is wrong.
        step(1'b0, 1'b1, 8'd7, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd7);
        n_checks++;
        if (mismatch_cnt !== 16'd1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL xform_mismatch: mismatch_cnt=%0d err=%b expected 1/1", mismatch_cnt, err);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_single_pulse: err=%b expected 0", err);
        end
        // Threshold boundary (4 -> 5) and wrap (255 -> 0), back to back.
        step(1'b0, 1'b1, 8'd4, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd255, 1'b1, 8'd5);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0);
        n_checks++;
        if (match_cnt !== 16'(m_match) || mismatch_cnt !== 16'd1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL xform_boundary: match=%0d mismatch=%0d pending=%0d expected %0d/1/0",
                     match_cnt, mismatch_cnt, pending, m_match);
        end
    endtask

    task automatic test_timeout();
        step(1'b0, 1'b1, 8'd2, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        n_checks++;
        if (pending !== 4'd1 || timeout_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_not_yet: pending=%0d timeout=%0d expected 1/0", pending, timeout_cnt);
        end
        step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        n_checks++;
        if (timeout_cnt !== 16'd1 || err !== 1'b1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout: timeout=%0d err=%b pending=%0d expected 1/1/0",
                     timeout_cnt, err, pending);
        end
    endtask

    task automatic test_spurious_overflow();
        step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0);
        n_checks++;
        if (spurious_cnt !== 16'd1 || err !== 1'b1 || b_spurious_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL spurious: spurious=%0d err=%b big_spurious=%0d expected 1/1/1",
                     spurious_cnt, err, b_spurious_cnt);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'd0);
        n_checks++;
        if (b_pending !== 4'd8 || b_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: big pending=%0d overflow=%b expected 8/0", b_pending, b_overflow);
        end
        step(1'b0, 1'b1, 8'd8, 1'b0, 8'd0);
        n_checks++;
        if (b_pending !== 4'd8 || b_overflow !== 1'b1 || b_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: big pending=%0d overflow=%b err=%b expected 8/1/1",
                     b_pending, b_overflow, b_err);
        end
        // The short-window instance timed entries out instead of filling.
        n_checks++;
        if (pending !== 4'(q_exp.size()) || timeout_cnt !== 16'(m_tmo) || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL short_window_fill: pending=%0d timeout=%0d overflow=%b expected %0d/%0d/%b",
                     pending, timeout_cnt, overflow, q_exp.size(), m_tmo, m_ovf);
        end
        // Full queue with a same-cycle pop: the push is accepted.
        step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd100, 1'b1, 8'd0);
        n_checks++;
        if (b_pending !== 4'd8 || b_overflow !== 1'b0 || b_match_cnt !== 16'd1 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: big pending=%0d overflow=%b match=%0d err=%b expected 8/0/1/0",
                     b_pending, b_overflow, b_match_cnt, b_err);
        end
        n_checks++;
        if ({b_mismatch_cnt, b_early_cnt, b_timeout_cnt} !== 48'd0) begin
            n_fail++;
            $display("FAIL full_push_pop_other: big mismatch=%0d early=%0d timeout=%0d expected 0/0/0",
                     b_mismatch_cnt, b_early_cnt, b_timeout_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i + 10), 1'b0, 8'd0);
        n_checks++;
        if (pending !== 4'd3) begin
            n_fail++;
            $display("FAIL three_pending: pending=%0d expected 3", pending);
        end
        step(1'b1, 1'b1, 8'd1, 1'b1, 8'd1);
        n_checks++;
        if (pending !== 4'd0 || {match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt} !== 80'd0
            || overflow !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset: pending=%0d counters=%h overflow=%b err=%b expected zeros",
                     pending, {match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt}, overflow, err);
        end
        step(1'b0, 1'b1, 8'd20, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 8'd21);
        n_checks++;
        if (match_cnt !== 16'd1 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL after_reset_match: match=%0d pending=%0d expected 1/0", match_cnt, pending);
        end
    endtask

    task automatic test_random();
        logic       r, ie, oe;
        logic [7:0] pi, po;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            ie = ($urandom_range(0, 2) != 0);
            oe = ($urandom_range(0, 1) != 0);
            pi = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            po = 8'($urandom);
            if (q_exp.size() != 0 && $urandom_range(0, 3) != 0) po = q_exp[0];
            step(r, ie, pi, oe, po);
            n_checks++;
            if (match_cnt !== 16'(m_match) || mismatch_cnt !== 16'(m_mism) || early_cnt !== 16'(m_early)
                || timeout_cnt !== 16'(m_tmo) || spurious_cnt !== 16'(m_spur)) begin
                n_fail++;
                $display("FAIL random_counters cycle %0d: got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                         n, match_cnt, mismatch_cnt, early_cnt, timeout_cnt, spurious_cnt,
                         m_match, m_mism, m_early, m_tmo, m_spur);
            end
            n_checks++;
            if (pending !== 4'(q_exp.size()) || overflow !== m_ovf || err !== m_err) begin
                n_fail++;
                $display("FAIL random_flags cycle %0d: pending=%0d overflow=%b err=%b expected %0d/%b/%b",
                         n, pending, overflow, err, q_exp.size(), m_ovf, m_err);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_match();
        test_xform();
        test_timeout();
        test_spurious_overflow();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
